// File: rtl/cpu_pkg.sv
// Shared definitions for the lab CPU control sequencer: ALU op codes, FSM states,
// condition codes, flag positions and the instruction decoder.
package cpu_pkg;

  localparam logic [10:0] ALU_ADD  = 11'd0;
  localparam logic [10:0] ALU_ADDI = 11'd1;
  localparam logic [10:0] ALU_SUB  = 11'd2;
  localparam logic [10:0] ALU_AND  = 11'd3;
  localparam logic [10:0] ALU_ORR  = 11'd4;
  localparam logic [10:0] ALU_EOR  = 11'd5;
  localparam logic [10:0] ALU_MOV  = 11'd6;
  localparam logic [10:0] ALU_MVN  = 11'd7;
  localparam logic [10:0] ALU_CMP  = 11'd8;
  localparam logic [10:0] ALU_TST  = 11'd9;
  localparam logic [10:0] ALU_TEQ  = 11'd10;
  localparam logic [10:0] ALU_BIC  = 11'd11;
  localparam logic [10:0] ALU_B    = 11'd31;
  localparam logic [10:0] ALU_BL   = 11'd32;
  localparam logic [10:0] ALU_LDR  = 11'd41;
  localparam logic [10:0] ALU_STR  = 11'd42;

  typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK} state_t;
  typedef enum logic [1:0] {CLS_DP, CLS_CMP, CLS_BR, CLS_LS} iclass_t;

  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic        illegal;
    iclass_t     cls;
    logic [10:0] alu_op;
    logic        use_imm;
    logic [31:0] imm;
    logic        set_flags;
    logic        is_load;
    logic        is_link;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d = '0;
    case (ins[27:26])
      2'b00: begin
        d.cls       = CLS_DP;
        d.use_imm   = ins[25];
        d.imm       = ins[25] ? {20'd0, ins[11:0]} : 32'd0;
        d.set_flags = ins[20];
        case (ins[24:21])
          4'b0000: d.alu_op = ALU_AND;
          4'b0001: d.alu_op = ALU_EOR;
          4'b0010: d.alu_op = ALU_SUB;
          4'b0100: d.alu_op = ins[25] ? ALU_ADDI : ALU_ADD;
          4'b1000: begin d.alu_op = ALU_TST; d.cls = CLS_CMP; d.set_flags = 1'b1; end
          4'b1001: begin d.alu_op = ALU_TEQ; d.cls = CLS_CMP; d.set_flags = 1'b1; end
          4'b1010: begin d.alu_op = ALU_CMP; d.cls = CLS_CMP; d.set_flags = 1'b1; end
          4'b1100: d.alu_op = ALU_ORR;
          4'b1101: d.alu_op = ALU_MOV;
          4'b1110: d.alu_op = ALU_BIC;
          4'b1111: d.alu_op = ALU_MVN;
          default: d.illegal = 1'b1;
        endcase
      end
      2'b01: begin
        d.cls     = CLS_LS;
        d.use_imm = 1'b1;
        d.imm     = {20'd0, ins[11:0]};
        d.is_load = ins[20];
        d.alu_op  = ins[20] ? ALU_LDR : ALU_STR;
        d.illegal = !ins[23];
      end
      2'b10: begin
        if (ins[25]) begin
          d.cls     = CLS_BR;
          d.is_link = ins[24];
          d.alu_op  = ins[24] ? ALU_BL : ALU_B;
          d.imm     = {{6{ins[23]}}, ins[23:0], 2'b00};
        end else begin
          d.illegal = 1'b1;
        end
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_ctrl_seq_cond_check.sv
// Combinational condition-field evaluator against the NZCV flags.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle fetch/decode/execute sequencer: every output is a flop whose next value
// is computed alongside the next state, so each strobe lines up with the state it belongs to.
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter int RA_W     = 4,
  parameter int LINK_REG = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  input  logic [3:0]      alu_flags,
  input  logic            mem_ready,
  output logic            instr_req,
  output logic [10:0]     alu_ctl,
  output logic            use_imm,
  output logic [31:0]     imm,
  output logic [RA_W-1:0] rn_addr,
  output logic [RA_W-1:0] rm_addr,
  output logic [RA_W-1:0] rd_addr,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic            pc_en,
  output logic            branch_taken,
  output logic [31:0]     cpsr,
  output logic            illegal
);

  state_t          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [3:0]      nzcv_q, nzcv_d;
  logic [10:0]     alu_ctl_q, alu_ctl_d;
  logic [31:0]     imm_q, imm_d;
  logic [RA_W-1:0] rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
  logic            use_imm_q, use_imm_d, instr_req_q, instr_req_d;
  logic            reg_we_q, reg_we_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic            pc_en_q, pc_en_d, taken_q, taken_d, illegal_q, illegal_d;

  // In FETCH the incoming word is decoded directly so DECODE-cycle strobes can be registered.
  logic [31:0] cur_instr;
  dec_t        dec;
  logic        cond_pass, skip;

  assign cur_instr = (state_q == ST_FETCH) ? instr : instr_q;
  assign dec       = decode(cur_instr);
  assign skip      = !cond_pass || dec.illegal;

  cond_check u_cond (
    .cond (cur_instr[31:28]),
    .nzcv (nzcv_q),
    .pass (cond_pass)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    nzcv_d    = nzcv_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    rn_d      = rn_q;
    rm_d      = rm_q;
    rd_d      = rd_q;
    alu_ctl_d = 11'd0;
    reg_we_d  = 1'b0;
    mem_re_d  = 1'b0;
    mem_we_d  = 1'b0;
    pc_en_d   = 1'b0;
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          instr_d   = instr;
          use_imm_d = dec.use_imm;
          imm_d     = dec.imm;
          rn_d      = RA_W'(cur_instr[19:16]);
          rm_d      = RA_W'(cur_instr[3:0]);
          rd_d      = dec.is_link ? RA_W'(LINK_REG) : RA_W'(cur_instr[15:12]);
          pc_en_d   = skip;
          illegal_d = dec.illegal;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (skip) begin
          state_d = ST_FETCH;
        end else begin
          state_d   = ST_EXECUTE;
          alu_ctl_d = dec.alu_op;
          if (dec.cls == CLS_BR) begin
            pc_en_d  = 1'b1;
            taken_d  = 1'b1;
            reg_we_d = dec.is_link;
          end else if (dec.cls == CLS_CMP) begin
            pc_en_d = 1'b1;
          end
        end
      end
      ST_EXECUTE: begin
        if (dec.set_flags) nzcv_d = alu_flags;
        case (dec.cls)
          CLS_DP: begin
            state_d  = ST_WRITEBACK;
            reg_we_d = 1'b1;
            pc_en_d  = 1'b1;
          end
          CLS_LS: begin
            state_d   = ST_MEM;
            alu_ctl_d = dec.alu_op;
            mem_re_d  = dec.is_load;
            mem_we_d  = !dec.is_load;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          pc_en_d  = 1'b1;
          reg_we_d = dec.is_load;
          state_d  = dec.is_load ? ST_WRITEBACK : ST_FETCH;
        end else begin
          alu_ctl_d = dec.alu_op;
          mem_re_d  = dec.is_load;
          mem_we_d  = !dec.is_load;
        end
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
    instr_req_d = (state_d == ST_FETCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      instr_q     <= '0;
      nzcv_q      <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      rn_q        <= '0;
      rm_q        <= '0;
      rd_q        <= '0;
      alu_ctl_q   <= '0;
      instr_req_q <= 1'b0;
      reg_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      pc_en_q     <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      nzcv_q      <= nzcv_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      rn_q        <= rn_d;
      rm_q        <= rm_d;
      rd_q        <= rd_d;
      alu_ctl_q   <= alu_ctl_d;
      instr_req_q <= instr_req_d;
      reg_we_q    <= reg_we_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      pc_en_q     <= pc_en_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
    end
  end

  assign instr_req    = instr_req_q;
  assign alu_ctl      = alu_ctl_q;
  assign use_imm      = use_imm_q;
  assign imm          = imm_q;
  assign rn_addr      = rn_q;
  assign rm_addr      = rm_q;
  assign rd_addr      = rd_q;
  assign reg_we       = reg_we_q;
  assign mem_re       = mem_re_q;
  assign mem_we       = mem_we_q;
  assign pc_en        = pc_en_q;
  assign branch_taken = taken_q;
  assign cpsr         = {nzcv_q, 28'd0};
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Vector-table bench for cpu_ctrl_seq: each instruction is run to completion and the
// observed strobes, fields, latency and flags are compared against hand-derived values.
module tb_cpu_ctrl_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        instr_req;
  logic [10:0] alu_ctl;
  logic        use_imm;
  logic [31:0] imm;
  logic [3:0]  rn_addr, rm_addr, rd_addr;
  logic        reg_we, mem_re, mem_we, pc_en, branch_taken, illegal;
  logic [31:0] cpsr;

  always #5 clk = ~clk;

  cpu_ctrl_seq #(.RA_W(4), .LINK_REG(14)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .alu_flags    (alu_flags),
    .mem_ready    (mem_ready),
    .instr_req    (instr_req),
    .alu_ctl      (alu_ctl),
    .use_imm      (use_imm),
    .imm          (imm),
    .rn_addr      (rn_addr),
    .rm_addr      (rm_addr),
    .rd_addr      (rd_addr),
    .reg_we       (reg_we),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .pc_en        (pc_en),
    .branch_taken (branch_taken),
    .cpsr         (cpsr),
    .illegal      (illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags;
    int          mem_wait;
    int          exp_len;
    logic [10:0] exp_alu;
    logic [31:0] exp_imm;
    logic        exp_taken;
    int          exp_we;
    logic [3:0]  exp_rd;
    logic [3:0]  exp_rn;
    logic [3:0]  exp_rm;
    logic        exp_ill;
    int          exp_mem;
    logic [3:0]  exp_nzcv;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];
  vec_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL v%0d %s: got 0x%0h, expected 0x%0h", id, name, act, exp);
  endtask

  task automatic run_vec(input int id);
    vec_t v, e;
    int n = 0, len = -1, pc_cnt = 0, we_cnt = 0, mem_cnt = 0;
    logic taken = 1'b0, ill = 1'b0;
    logic [10:0] alu_seen = '0;
    logic [31:0] imm_seen = '0;
    logic [3:0]  rd_seen = '0, rn_seen = '0, rm_seen = '0;
    v = vecs[id];
    while (!instr_req && n < 10) begin @(negedge clk); n++; end
    chk("req", id, 32'(instr_req), 32'd1);
    instr = v.instr; alu_flags = v.flags; instr_valid = 1'b1;
    exp_q.push_back(v);
    @(posedge clk);
    #1 instr_valid = 1'b0; instr = 32'h0;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      if (i == 1) begin rn_seen = rn_addr; rm_seen = rm_addr; end
      if (i == 2) alu_seen = alu_ctl;
      if (pc_en) begin pc_cnt++; taken = branch_taken; imm_seen = imm; end
      if (reg_we) begin we_cnt++; rd_seen = rd_addr; end
      if (illegal) ill = 1'b1;
      if (mem_re || mem_we) mem_cnt++;
      mem_ready = (mem_re || mem_we) && (mem_cnt >= v.mem_wait);
      if (instr_req) begin len = i; break; end
    end
    mem_ready = 1'b0;
    e = exp_q.pop_front();
    chk("len", id, 32'(len), 32'(e.exp_len));
    chk("pc_en_count", id, 32'(pc_cnt), 32'd1);
    chk("branch_taken", id, 32'(taken), 32'(e.exp_taken));
    chk("imm", id, imm_seen, e.exp_imm);
    chk("reg_we_count", id, 32'(we_cnt), 32'(e.exp_we));
    if (e.exp_we > 0) chk("rd", id, 32'(rd_seen), 32'(e.exp_rd));
    chk("rn", id, 32'(rn_seen), 32'(e.exp_rn));
    chk("rm", id, 32'(rm_seen), 32'(e.exp_rm));
    chk("illegal", id, 32'(ill), 32'(e.exp_ill));
    chk("mem_cycles", id, 32'(mem_cnt), 32'(e.exp_mem));
    if (e.exp_len > 2) chk("alu_ctl", id, 32'(alu_seen), 32'(e.exp_alu));
    chk("cpsr", id, cpsr, {e.exp_nzcv, 28'd0});
  endtask

  initial begin
    int n;
    int stray;
    logic req_seen;
    reset = 1'b1; instr = '0; instr_valid = 1'b0; alu_flags = '0; mem_ready = 1'b0;
    //            instr         flg  wt len alu     imm            tk we rd  rn  rm  ill mem nzcv
    vecs[0]  = '{32'hE0821003, 4'h0, 0, 4, 11'd0,  32'h0,        0, 1, 1,  2,  3,  0, 0, 4'h0};
    vecs[1]  = '{32'hE1510002, 4'h4, 0, 3, 11'd8,  32'h0,        0, 0, 0,  1,  2,  0, 0, 4'h4};
    vecs[2]  = '{32'h0A000002, 4'h0, 0, 3, 11'd31, 32'h8,        1, 0, 0,  0,  2,  0, 0, 4'h4};
    vecs[3]  = '{32'h1A000002, 4'h0, 0, 2, 11'd0,  32'h8,        0, 0, 0,  0,  2,  0, 0, 4'h4};
    vecs[4]  = '{32'hE5910004, 4'h0, 3, 7, 11'd41, 32'h4,        0, 1, 0,  1,  4,  0, 3, 4'h4};
    vecs[5]  = '{32'hE5810008, 4'h0, 1, 4, 11'd42, 32'h8,        0, 0, 0,  1,  8,  0, 1, 4'h4};
    vecs[6]  = '{32'hEB000010, 4'h0, 0, 3, 11'd32, 32'h40,       1, 1, 14, 0,  0,  0, 0, 4'h4};
    vecs[7]  = '{32'hE0600000, 4'h0, 0, 2, 11'd0,  32'h0,        0, 0, 0,  0,  0,  1, 0, 4'h4};
    vecs[8]  = '{32'hEAFFFFFE, 4'h0, 0, 3, 11'd31, 32'hFFFFFFF8, 1, 0, 0,  15, 14, 0, 0, 4'h4};
    vecs[9]  = '{32'hE2911005, 4'h9, 0, 4, 11'd1,  32'h5,        0, 1, 1,  1,  5,  0, 0, 4'h9};
    vecs[10] = '{32'hB3A02007, 4'h0, 0, 2, 11'd0,  32'h7,        0, 0, 0,  0,  7,  0, 0, 4'h9};
    vecs[11] = '{32'hC1E03004, 4'h0, 0, 4, 11'd7,  32'h0,        0, 1, 3,  0,  4,  0, 0, 4'h9};
    vecs[12] = '{32'hF0821003, 4'h0, 0, 2, 11'd0,  32'h0,        0, 0, 0,  2,  3,  0, 0, 4'h9};
    vecs[13] = '{32'hE1110002, 4'h0, 0, 3, 11'd9,  32'h0,        0, 0, 0,  1,  2,  0, 0, 4'h0};
    vecs[14] = '{32'hE5110004, 4'h0, 0, 2, 11'd0,  32'h4,        0, 0, 0,  1,  4,  1, 0, 4'h0};
    vecs[15] = '{32'hE1812003, 4'h0, 0, 4, 11'd4,  32'h0,        0, 1, 2,  1,  3,  0, 0, 4'h0};
    vecs[16] = '{32'hE1510002, 4'h6, 0, 3, 11'd8,  32'h0,        0, 0, 0,  1,  2,  0, 0, 4'h6};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_req", -1, 32'(instr_req), 32'd0);
    chk("rst_pc_en", -1, 32'(pc_en), 32'd0);
    chk("rst_reg_we", -1, 32'(reg_we), 32'd0);
    chk("rst_mem", -1, 32'({mem_re, mem_we}), 32'd0);
    chk("rst_alu_imm", -1, {21'd0, alu_ctl} | imm, 32'd0);
    chk("rst_cpsr", -1, cpsr, 32'd0);
    chk("rst_illegal", -1, 32'(illegal), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < NV; k++) run_vec(k);

    // LDR stalled in MEM, then reset: access must drop and nothing may retire.
    n = 0;
    while (!instr_req && n < 10) begin @(negedge clk); n++; end
    instr = 32'hE5910004; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0;
    while (!mem_re && n < 10) begin @(negedge clk); n++; end
    chk("mid_mem_re", -2, 32'(mem_re), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_mem_re", -2, 32'(mem_re), 32'd0);
    chk("rst_mid_cpsr", -2, cpsr, 32'd0);
    chk("rst_mid_strobes", -2, 32'({reg_we, pc_en}), 32'd0);
    reset = 1'b0; mem_ready = 1'b1;
    stray = 0; req_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (reg_we || pc_en || mem_re || mem_we) stray++;
      if (instr_req) req_seen = 1'b1;
    end
    mem_ready = 1'b0;
    chk("post_rst_fetch", -2, 32'(req_seen), 32'd1);
    chk("stale_ready_ignored", -2, 32'(stray), 32'd0);
    run_vec(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
